// File: rtl/nios_accelerometer_button_event_ctrl.sv
// -----------------------------------------------------------------------------
// nios_accelerometer_button_event_ctrl
//
// Avalon-MM slave between the raw push-button pins and the Nios II CPU.
// Each button is synchronised (2 flops), debounced by a per-bit 2-state FSM,
// and edge-detected with a software-selected polarity. Detected edges latch
// into a sticky, write-1-to-clear capture register, and a maskable level
// interrupt is raised while any enabled flag is set.
//
// Register map (word address; unused upper bits read 0):
//   0 DATA     RO    debounced levels
//   1 MASK     RW    irq enable per bit
//   2 EDGECAP  R/W1C sticky edge flags
//   3 EDGESEL  RW    0 = capture rising, 1 = capture falling
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   address           register select (word address)
//   chipselect        slave select; qualifies read and write
//   read, write       bus strobes
//   writedata         write data (low WIDTH bits used)
//   readdata          registered read data
//   in_port           raw asynchronous button pins
//   irq               registered level interrupt
//   o_dbg_settling    per-bit debounce FSM state (1 = SETTLING)
//
// Bus handshake: zero-wait-state slave with no back-pressure. A write takes
// effect on the clock edge where chipselect & write are high. readdata is
// reloaded every cycle from the register selected by address, so it presents
// the previous cycle's selection one cycle later; reads have no side effects.
// -----------------------------------------------------------------------------
module nios_accelerometer_button_event_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq,
    output logic [WIDTH-1:0] o_dbg_settling
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } deb_state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    deb_state_t       r_state     [WIDTH];
    deb_state_t       w_state_nxt [WIDTH];
    logic [CNT_W-1:0] r_cnt       [WIDTH];
    logic [CNT_W-1:0] w_cnt_nxt   [WIDTH];

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] w_stable_nxt;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] r_init_done;
    logic [WIDTH-1:0] w_init_nxt;
    logic [WIDTH-1:0] r_init_d;

    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_edgesel;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      r_readdata;
    logic [31:0]      w_rd_mux;
    logic             r_irq;

    logic w_wr;
    logic w_wr1;
    logic w_wr2;
    logic w_wr3;
    logic w_unused_bits;

    assign w_unused_bits = ^{read, writedata[31:WIDTH]};

    // Debounce FSM state register plus the synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_stable    <= '0;
            r_stable_d  <= '0;
            r_init_done <= '0;
            r_init_d    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_sync1     <= in_port;
            r_sync2     <= r_sync1;
            r_stable    <= w_stable_nxt;
            r_stable_d  <= r_stable;
            r_init_done <= w_init_nxt;
            r_init_d    <= r_init_done;
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // Next-state logic. The settle fires on the cycle whose incremented count
    // reaches DEBOUNCE_CYCLES-1, so sync must hold for DEBOUNCE_CYCLES samples.
    always_comb begin
        w_stable_nxt = r_stable;
        w_init_nxt   = r_init_done;
        for (int i = 0; i < WIDTH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_STABLE: begin
                    if (r_sync2[i] != r_stable[i]) begin
                        w_state_nxt[i] = ST_SETTLING;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                ST_SETTLING: begin
                    if (r_sync2[i] == r_stable[i]) begin
                        w_state_nxt[i] = ST_STABLE;
                    end else if ((r_cnt[i] + CNT_W'(1)) == LP_LAST) begin
                        w_stable_nxt[i] = r_sync2[i];
                        w_init_nxt[i]   = 1'b1;
                        w_state_nxt[i]  = ST_STABLE;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_STABLE;
                end
            endcase
        end
    end

    always_comb begin
        o_dbg_settling = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_dbg_settling[i] = (r_state[i] == ST_SETTLING);
        end
    end

    // The delayed init flag keeps the settle that sets init_done from
    // counting as an edge (idle-high keys would otherwise fire after reset).
    // stable ^ edgesel is 1 for a rise when edgesel=0 and a fall when edgesel=1.
    assign w_edge = r_init_d & (r_stable ^ r_stable_d) & (r_stable ^ r_edgesel);

    assign w_wr  = chipselect & write;
    assign w_wr1 = w_wr & (address == 2'd1);
    assign w_wr2 = w_wr & (address == 2'd2);
    assign w_wr3 = w_wr & (address == 2'd3);
    assign w_clr = {WIDTH{w_wr2}} & writedata[WIDTH-1:0];

    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0:    w_rd_mux[WIDTH-1:0] = r_stable;
            2'd1:    w_rd_mux[WIDTH-1:0] = r_mask;
            2'd2:    w_rd_mux[WIDTH-1:0] = r_edgecap;
            default: w_rd_mux[WIDTH-1:0] = r_edgesel;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask     <= '0;
            r_edgecap  <= '0;
            r_edgesel  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr1) r_mask    <= writedata[WIDTH-1:0];
            if (w_wr3) r_edgesel <= writedata[WIDTH-1:0];
            // Set has priority over W1C so an edge racing a clear is kept.
            r_edgecap  <= w_edge | (r_edgecap & ~w_clr);
            r_irq      <= |(r_edgecap & r_mask);
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_nios_accelerometer_button_event_ctrl.sv
module tb_nios_accelerometer_button_event_ctrl;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [1:0]  in_port = 2'b11;
    logic        irq;
    logic [1:0]  dbg_settling;

    int n_cmp = 0;
    int n_bad = 0;
    int n_print = 0;
    bit chk_en = 1'b0;

    nios_accelerometer_button_event_ctrl #(
        .WIDTH(2),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq),
        .o_dbg_settling(dbg_settling)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Pins reach the debouncer after two samples; a debounced level follows
    // the synchronised level once the last DC samples all agree. A level
    // change is an event only if that bit had settled high before; it is
    // judged against EDGESEL one cycle later and lands in EDGECAP then.
    logic [1:0]  m_p1, m_p2, m_stable, m_init, m_pend;
    logic [1:0]  m_mask, m_edgecap, m_edgesel;
    logic        m_irq;
    logic [31:0] m_rd;
    logic [1:0]  m_hist[$];

    always @(posedge clk or negedge reset_n) begin : model_step
        logic [1:0] ev;
        logic [1:0] chg;
        logic [1:0] clr;
        bit all1;
        bit all0;
        if (!reset_n) begin
            m_p1 = '0; m_p2 = '0; m_stable = '0; m_init = '0; m_pend = '0;
            m_mask = '0; m_edgecap = '0; m_edgesel = '0;
            m_irq = 1'b0; m_rd = '0;
            m_hist.delete();
        end else begin
            m_rd = '0;
            case (address)
                2'd0: m_rd[1:0] = m_stable;
                2'd1: m_rd[1:0] = m_mask;
                2'd2: m_rd[1:0] = m_edgecap;
                default: m_rd[1:0] = m_edgesel;
            endcase
            m_irq = (m_edgecap & m_mask) != 2'b00;
            for (int i = 0; i < 2; i++)
                ev[i] = m_pend[i] && (m_stable[i] != m_edgesel[i]);
            clr = (chipselect && write && address == 2'd2) ? writedata[1:0] : 2'b00;
            m_edgecap = ev | (m_edgecap & ~clr);
            if (chipselect && write && address == 2'd1) m_mask = writedata[1:0];
            if (chipselect && write && address == 2'd3) m_edgesel = writedata[1:0];
            m_hist.push_back(m_p2);
            if (m_hist.size() > DC) void'(m_hist.pop_front());
            chg = 2'b00;
            for (int i = 0; i < 2; i++) begin
                all1 = 1'b1;
                all0 = 1'b1;
                foreach (m_hist[k]) begin
                    if (m_hist[k][i]) all0 = 1'b0;
                    else all1 = 1'b0;
                end
                if (m_hist.size() == DC)
                    chg[i] = (all1 && !m_stable[i]) || (all0 && m_stable[i]);
            end
            m_pend = chg & m_init;
            m_init = m_init | chg;
            m_stable = m_stable ^ chg;
            m_p2 = m_p1;
            m_p1 = in_port;
        end
    end

    // ---------------- cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (readdata !== m_rd || irq !== m_irq) begin
                n_bad++;
                if (n_print < 20) begin
                    n_print++;
                    $display("FAIL model_cycle t=%0t: readdata=%0h irq=%0b, model readdata=%0h irq=%0b",
                             $time, readdata, irq, m_rd, m_irq);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        logic [1:0] keep;
        keep = address;
        chipselect = 1'b1;
        write = 1'b1;
        address = a;
        writedata = d;
        tick();
        write = 1'b0;
        address = keep;
        writedata = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hold;
        chipselect = 1'b1;
        read = 1'b1;
        #1 reset_n = 1'b0;
        chk_en = 1'b1;

        // 1: keys held high through reset
        in_port = 2'b11;
        address = 2'd0;
        tick(); tick(); tick();
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        reset_n = 1'b1;
        repeat (6) tick();
        chk("rst_data_not_yet", readdata, 32'h0);
        tick();
        chk("rst_data_settled", readdata, 32'h3);
        address = 2'd2;
        tick();
        chk("rst_no_edgecap", readdata, 32'h0);
        chk("rst_no_irq", {31'd0, irq}, 32'h0);

        // 2: bounce on bit 0 shorter than the debounce window
        address = 2'd0;
        for (int k = 0; k < 5; k++) begin
            in_port[0] = 1'b0; tick(); tick();
            in_port[0] = 1'b1; tick(); tick();
        end
        repeat (8) tick();
        chk("bounce_data", readdata, 32'h3);
        address = 2'd2;
        tick();
        chk("bounce_edgecap", readdata, 32'h0);

        // 3: falling-edge press on bit 0
        bus_write(2'd3, 32'h1);
        bus_write(2'd1, 32'h1);
        address = 2'd2;
        in_port[0] = 1'b0;
        repeat (7) tick();
        chk("press_cap_before", readdata, 32'h0);
        chk("press_irq_before", {31'd0, irq}, 32'h0);
        tick();
        chk("press_cap", readdata, 32'h1);
        chk("press_irq", {31'd0, irq}, 32'h1);
        bus_write(2'd2, 32'h1);
        chk("clr_irq_hold", {31'd0, irq}, 32'h1);
        tick();
        chk("clr_irq_fall", {31'd0, irq}, 32'h0);
        chk("clr_cap", readdata, 32'h0);

        // 4: W1C on the same edge as a new captured event
        in_port[0] = 1'b1;
        repeat (10) tick();
        chk("release_not_captured", readdata, 32'h0);
        in_port[0] = 1'b0;
        repeat (6) tick();
        chipselect = 1'b1; write = 1'b1; address = 2'd2; writedata = 32'h1;
        tick();
        write = 1'b0; writedata = '0;
        tick();
        chk("race_cap_kept", readdata, 32'h1);
        chk("race_irq", {31'd0, irq}, 32'h1);
        bus_write(2'd2, 32'h1);
        chk("race_clr_irq_hold", {31'd0, irq}, 32'h1);
        tick();
        chk("race_clr_irq_fall", {31'd0, irq}, 32'h0);
        chk("race_clr_cap", readdata, 32'h0);

        // 5: masked flag on bit 1 (rising edge)
        in_port[1] = 1'b0;
        repeat (10) tick();
        in_port[1] = 1'b1;
        repeat (10) tick();
        chk("mask_cap1", readdata, 32'h2);
        chk("mask_irq_off", {31'd0, irq}, 32'h0);
        bus_write(2'd1, 32'h3);
        chk("mask_irq_write_cycle", {31'd0, irq}, 32'h0);
        tick();
        chk("mask_irq_on", {31'd0, irq}, 32'h1);

        // 6: reset while bit 1 is part-way through a settle
        in_port[1] = 1'b0;
        repeat (5) tick();
        chk("mid_settle_dbg", {30'd0, dbg_settling}, 32'h2);
        reset_n = 1'b0;
        in_port = 2'b11;
        #1;
        chk("async_rst_readdata", readdata, 32'h0);
        chk("async_rst_irq", {31'd0, irq}, 32'h0);
        chk("async_rst_dbg", {30'd0, dbg_settling}, 32'h0);
        tick(); tick();
        reset_n = 1'b1;
        address = 2'd0;
        repeat (6) tick();
        chk("rst2_data_not_yet", readdata, 32'h0);
        tick();
        chk("rst2_data_settled", readdata, 32'h3);
        address = 2'd2;
        tick();
        chk("rst2_no_edgecap", readdata, 32'h0);
        chk("rst2_no_irq", {31'd0, irq}, 32'h0);

        // random phase against the model
        hold = 0;
        for (int c = 0; c < 2500; c++) begin
            if (hold == 0) begin
                in_port[$urandom_range(0, 1)] = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 7);
            end
            hold--;
            chipselect = ($urandom_range(0, 3) != 0);
            write = ($urandom_range(0, 4) == 0);
            read = 1'b1;
            address = 2'($urandom_range(0, 3));
            writedata = $urandom;
            if (c == 1200) reset_n = 1'b0;
            if (c == 1203) reset_n = 1'b1;
            tick();
        end
        chipselect = 1'b0;
        write = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
